mux8_scan_seq: RTL

Upstream sequencer for the 8:1 bit multiplexer (`mux8x1`). Accepts an 8-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the mux select through all eight positions. Each selected bit is presented as a framed serial stream with `ser_valid` and `ser_last`. It converts the combinational mux into a parallel-to-serial stage with programmable bit period and bit order.

---
 rtl/mux8_scan_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mux8_scan_seq.sv
// mux8_scan_seq
//
// Upstream sequencer for an external 8:1 bit multiplexer (mux8x1). A word is
// accepted over a valid/ready handshake and held on the mux data inputs. The
// mux select is then stepped through all eight positions, so the mux output
// becomes a framed serial stream. Each bit is held for BIT_CYCLES clocks. Bit
// order is LSB first (select 0..7) or, when MSB_FIRST is set, MSB first
// (select 7..0).
//
// Parameters
//   BIT_CYCLES   clocks each bit is held, 1..255
//   MSB_FIRST    0: select order 0->7, 1: select order 7->0
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   load_data_i   word to serialize
//   load_valid_i  load_data_i is valid
//   load_ready_o  a word can be accepted (IDLE)
//   abort_i       synchronous cancel of the word in progress
//   mux_in_o      registered word, drives mux8x1.in
//   mux_sel_o     registered select, drives mux8x1.sel
//   mux_out_i     returned mux8x1.out
//   ser_data_o    current serial bit, a direct pass-through of mux_out_i
//   ser_valid_o   ser_data_o carries a live bit
//   ser_last_o    current bit is the eighth bit of the word
//   busy_o        serialization in progress

module mux8_scan_seq #(
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] load_data_i,
    input  logic       load_valid_i,
    output logic       load_ready_o,
    input  logic       abort_i,
    output logic [7:0] mux_in_o,
    output logic [2:0] mux_sel_o,
    input  logic       mux_out_i,
    output logic       ser_data_o,
    output logic       ser_valid_o,
    output logic       ser_last_o,
    output logic       busy_o
);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    // Terminal value of the period counter and the first/last select positions.
    localparam logic [7:0] PerLast  = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] SelFirst = MSB_FIRST ? 3'd7 : 3'd0;

    state_e     state_q, state_d;
    logic [7:0] mux_in_q, mux_in_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] per_cnt_q, per_cnt_d;

    logic       per_wrap;
    logic [2:0] sel_step;

    assign per_wrap = (per_cnt_q == PerLast);
    assign sel_step = MSB_FIRST ? (mux_sel_q - 3'd1) : (mux_sel_q + 3'd1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mux_in_d  = mux_in_q;
        mux_sel_d = mux_sel_q;
        bit_cnt_d = bit_cnt_q;
        per_cnt_d = per_cnt_q;

        unique case (state_q)
            StIdle: begin
                // abort_i is deliberately ignored here: a load alongside an
                // abort in IDLE is still accepted.
                if (load_valid_i) begin
                    state_d   = StShift;
                    mux_in_d  = load_data_i;
                    mux_sel_d = SelFirst;
                    bit_cnt_d = 3'd0;
                    per_cnt_d = 8'd0;
                end
            end

            StShift: begin
                if (abort_i) begin
                    state_d   = StIdle;
                    mux_sel_d = 3'd0;
                    bit_cnt_d = 3'd0;
                    per_cnt_d = 8'd0;
                end else if (per_wrap) begin
                    per_cnt_d = 8'd0;
                    if (bit_cnt_q == 3'd7) begin
                        // Word complete; mux_in keeps the last word.
                        state_d   = StIdle;
                        mux_sel_d = 3'd0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        mux_sel_d = sel_step;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    per_cnt_d = per_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = StIdle;
                mux_sel_d = 3'd0;
                bit_cnt_d = 3'd0;
                per_cnt_d = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mux_in_q  <= 8'h00;
            mux_sel_q <= 3'd0;
            bit_cnt_q <= 3'd0;
            per_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            mux_in_q  <= mux_in_d;
            mux_sel_q <= mux_sel_d;
            bit_cnt_q <= bit_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded straight from registers, so the asynchronous reset
    // takes effect on them without waiting for a clock edge.
    // ------------------------------------------------------------------------
    assign mux_in_o     = mux_in_q;
    assign mux_sel_o    = mux_sel_q;
    assign ser_data_o   = mux_out_i;
    assign ser_valid_o  = (state_q == StShift);
    assign busy_o       = (state_q == StShift);
    assign load_ready_o = (state_q == StIdle);
    assign ser_last_o   = (state_q == StShift) && (bit_cnt_q == 3'd7);

`ifndef SYNTHESIS
    // The select always parks at 0 between words.
    a_sel_parked : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StIdle) |-> (mux_sel_q == 3'd0));

    // The period counter never runs past the bit period.
    a_per_range : assert property (@(posedge clk) disable iff (!rst_n)
        per_cnt_q <= PerLast);
`endif

endmodule
